bcd_counter_bank: RTL and testbench
===================================

# bcd_counter_bank

Multi-digit BCD counter bank that sits directly downstream of the input trigger/debounce stage. It consumes the `inc_clk` increment pulse and the `ref_clk` refresh pulse, plus the live per-digit trigger levels. On each increment pulse it adds one to every digit whose button is held, and ripples carries one digit per clock. On each refresh pulse it publishes a stable snapshot, which it also drives to a multiplexed 7-segment display.

## Interface
- `DIGITS`, 6, number of BCD digits; legal range 1..15, so a full carry ripple always finishes inside the upstream 16-cycle calculation window.
- `SCAN_DIV`, 1024, clock cycles per display digit slot; ≥2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `inc_clk`  in  1  single-cycle increment pulse from the trigger stage.
- `ref_clk`  in  1  single-cycle refresh pulse from the trigger stage.
- `trigger`  in  DIGITS  per-digit button levels; bit i selects digit i; sampled only on `inc_clk`.
- `count_bcd`  out  4*DIGITS  published snapshot; digit i is bits [4i+3:4i].
- `busy`  out  1  high while a carry ripple is pending.
- `overflow`  out  1  sticky flag: the most significant digit wrapped 9→0.
- `seg`  out  7  segment pattern {g,f,e,d,c,b,a}, active-high, for the currently scanned digit.
- `dig_sel`  out  DIGITS  one-hot active-high digit enable.

## Operation
- Working register `work`: DIGITS×4-bit BCD. Carry vector `cy`: DIGITS bits; `cy[i]` means "increment digit i".
- FSM states:
  - IDLE: on `inc_clk`, load `cy = trigger` and go to RIPPLE; otherwise stay in IDLE.
  - RIPPLE: each cycle, every digit with `cy[i]=1` steps 9→0 or n→n+1.
  - Next `cy[i+1]` is set only where digit i wrapped 9→0; all other bits clear.
  - A wrap of digit DIGITS-1 sets `overflow`; that carry is discarded.
  - Return to IDLE when the next `cy` is all zero.
- `trigger=0` on an `inc_clk`: one RIPPLE cycle with no change, then IDLE.
- `inc_clk` while in RIPPLE is ignored. The upstream stage guarantees pulses are ≥8192 cycles apart.
- `ref_clk`: `count_bcd <= work`, sampled at that edge.
  - If coincident with a RIPPLE update, the snapshot takes the pre-update value.
  - In normal upstream timing (`ref_clk` 16 cycles after `inc_clk`), the ripple has already finished.
- Digit values are always 0..9; there is no non-BCD state.
- Display scan:
  - Free-running divider counts 0..SCAN_DIV-1.
  - On terminal count, the scan index advances modulo DIGITS.
  - `dig_sel = 1<<index`.
  - `seg` shows the standard 0–9 decode of `count_bcd` digit[index]; the display never shows `work`.
- Reset values: `work`=0, `cy`=0, FSM=IDLE, `count_bcd`=0, `overflow`=0, `busy`=0, divider=0, index=0, `dig_sel`=1, `seg`=7'b0111111 (digit "0").
- Reset mid-ripple aborts the ripple immediately; no partial state survives.

## Timing
- `inc_clk` high at edge n → state RIPPLE from edge n; selected digits update at edge n+1.
- Carry into digit i+1 lands at edge n+2, and so on.
- Worst case (all digits 9, `trigger` = bit 0): the last digit updates at edge n+DIGITS; IDLE at the same edge.
- `busy` is a registered output: high for cycles after edge n until the edge that returns to IDLE.
- `count_bcd` changes only on the edge where `ref_clk` is sampled high, with 1-cycle latency.
- `seg` and `dig_sel` are registered and change together, once per SCAN_DIV cycles.

## Structure
- Shared package `counter_pkg`:
  - BCD digit type (4-bit).
  - Constant `BCD_MAX=4'd9`.
  - FSM state encoding (IDLE/RIPPLE).
  - 7-segment patterns for 0–9.
- One natural sub-module: `seg7_scan`. It holds the divider, scan index and decode, with `count_bcd` as input. The ripple FSM stays in `bcd_counter_bank`.

## Test plan
- Reset, then `inc_clk` with `trigger=6'b000001`, then `ref_clk` 16 cycles later → `count_bcd=24'h000001`, `overflow=0`.
- Preload digits 0..3 to 9 via 9 pulses each, then `inc_clk` with `trigger=6'b000001`:
  - digits 0..3 clear on successive edges n+1..n+4, digit 4 becomes 1 at n+5;
  - `busy` high for exactly 5 cycles; after `ref_clk`, `count_bcd=24'h010000`.
- `trigger=6'b100100` on a single `inc_clk` from zero → after `ref_clk`, `count_bcd=24'h100100`.
- All digits at 9, `inc_clk` with `trigger=6'b000001` → `work`=0 after 6 cycles, `overflow`=1, and it stays 1 across further increments until reset.
- `ref_clk` coincident with the first RIPPLE edge → snapshot holds the old value; a second `ref_clk` later shows the new value.
- Assert `rst_n=0` during a ripple, asynchronously between edges → all outputs take reset values immediately; `count_bcd=0`, `dig_sel=6'b000001`.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD counter bank: digit type, ripple FSM
// encoding and the 7-segment decode used by the display scanner.
package counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic {
        IDLE   = 1'b0,
        RIPPLE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_ZERO  = 7'b0111111;

    // Active-high {g,f,e,d,c,b,a}; codes above 9 cannot occur but decode blank.
    function automatic logic [6:0] seg7_decode(input bcd_t digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b0111111;
            4'd1:    pattern = 7'b0000110;
            4'd2:    pattern = 7'b1011011;
            4'd3:    pattern = 7'b1001111;
            4'd4:    pattern = 7'b1100110;
            4'd5:    pattern = 7'b1101101;
            4'd6:    pattern = 7'b1111101;
            4'd7:    pattern = 7'b0000111;
            4'd8:    pattern = 7'b1111111;
            4'd9:    pattern = 7'b1101111;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment driver: free-running slot divider, scan index and a
// registered decode of the published snapshot digit for the current slot.
module seg7_scan
    import counter_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   count_bcd,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0] divider;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] next_index;
    logic             terminal;

    assign terminal = (divider == DIV_W'(SCAN_DIV - 1));

    always_comb begin
        next_index = index + IDX_W'(1);
        if (index == IDX_W'(DIGITS - 1)) begin
            next_index = '0;
        end
    end

    // Segment pattern and digit enable only move at a slot boundary, so the
    // lit digit never tears mid-slot even if the snapshot is refreshed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider <= '0;
            index   <= '0;
            dig_sel <= DIGITS'(1);
            seg     <= SEG_ZERO;
        end else begin
            divider <= terminal ? '0 : divider + DIV_W'(1);
            if (terminal) begin
                index   <= next_index;
                dig_sel <= DIGITS'(1) << next_index;
                seg     <= seg7_decode(count_bcd[4*int'(next_index) +: 4]);
            end
        end
    end

endmodule

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD counter bank: per-digit increments with a one-digit-per-clock
// carry ripple, sticky overflow, refresh snapshot and scanned 7-segment output.
module bcd_counter_bank
    import counter_pkg::*;
#(
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_clk,
    input  logic                  ref_clk,
    input  logic [DIGITS-1:0]     trigger,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    state_t             state;
    state_t             state_next;
    bcd_t [DIGITS-1:0]  work;
    bcd_t [DIGITS-1:0]  work_next;
    logic [DIGITS-1:0]  cy;
    logic [DIGITS-1:0]  cy_next;
    logic [DIGITS-1:0]  wrap;

    always_comb begin
        state_next = state;
        work_next  = work;
        cy_next    = cy;
        wrap       = '0;
        case (state)
            IDLE: begin
                if (inc_clk) begin
                    cy_next    = trigger;
                    state_next = RIPPLE;
                end
            end
            RIPPLE: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (cy[i]) begin
                        if (work[i] == BCD_MAX) begin
                            work_next[i] = '0;
                            wrap[i]      = 1'b1;
                        end else begin
                            work_next[i] = work[i] + 4'd1;
                        end
                    end
                end
                // A wrap only carries into the next digit; the top digit's carry is dropped.
                cy_next = '0;
                for (int i = 1; i < DIGITS; i++) begin
                    cy_next[i] = wrap[i-1];
                end
                if (cy_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cy        <= '0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            count_bcd <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            cy    <= cy_next;
            busy  <= (state_next == RIPPLE);
            if (wrap[DIGITS-1]) begin
                overflow <= 1'b1;
            end
            if (ref_clk) begin
                count_bcd <= work;
            end
        end
    end

    seg7_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .count_bcd (count_bcd),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Self-checking bench for bcd_counter_bank; the counter is modelled as a plain
// decimal integer to which each increment adds the weights of the held digits.
module tb_bcd_counter_bank;

    localparam int DIGITS   = 6;
    localparam int SCAN_DIV = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                inc_clk;
    logic                ref_clk;
    logic [DIGITS-1:0]   trigger;
    logic [4*DIGITS-1:0] count_bcd;
    logic                busy;
    logic                overflow;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   dig_sel;

    int     checks   = 0;
    int     failures = 0;
    longint model_val;
    bit     model_ovf;
    int     edges;
    logic [6:0] seg_table [10];

    bcd_counter_bank #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_clk   (inc_clk),
        .ref_clk   (ref_clk),
        .trigger   (trigger),
        .count_bcd (count_bcd),
        .busy      (busy),
        .overflow  (overflow),
        .seg       (seg),
        .dig_sel   (dig_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [4*DIGITS-1:0] to_bcd(input longint v);
        logic [4*DIGITS-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int digit_of(input longint v, input int i);
        return int'((v / pow10(i)) % 10);
    endfunction

    task automatic model_inc(input logic [DIGITS-1:0] trig);
        for (int i = 0; i < DIGITS; i++) begin
            if (trig[i]) model_val = model_val + pow10(i);
        end
        if (model_val >= pow10(DIGITS)) begin
            model_ovf = 1'b1;
            model_val = model_val % pow10(DIGITS);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc_clk = 1'b0;
        ref_clk = 1'b0;
        trigger = '0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        model_val = 0;
        model_ovf = 1'b0;
        tick();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            tick();
            cycles++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic pulse_inc(input logic [DIGITS-1:0] trig, output int cycles);
        trigger = trig;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        model_inc(trig);
        wait_idle(cycles);
    endtask

    task automatic refresh_check(input string name);
        ref_clk = 1'b1;
        tick();
        ref_clk = 1'b0;
        checks++;
        if (count_bcd !== to_bcd(model_val)) begin
            failures++;
            $display("[TB] FAIL %s count_bcd: got %h, required %h", name, count_bcd, to_bcd(model_val));
        end
        checks++;
        if (overflow !== model_ovf) begin
            failures++;
            $display("[TB] FAIL %s overflow: got %b, required %b", name, overflow, model_ovf);
        end
    endtask

    task automatic load_value(input longint v);
        int c;
        logic [DIGITS-1:0] trig;
        for (int k = 0; k < 9; k++) begin
            trig = '0;
            for (int i = 0; i < DIGITS; i++) trig[i] = (digit_of(v, i) > k);
            if (trig != '0) pulse_inc(trig, c);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count_bcd !== '0) begin failures++; $display("[TB] FAIL reset count_bcd: got %h, required 0", count_bcd); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %b, required 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset overflow: got %b, required 0", overflow); end
        checks++;
        if (dig_sel !== DIGITS'(1)) begin failures++; $display("[TB] FAIL reset dig_sel: got %b, required 000001", dig_sel); end
        checks++;
        if (seg !== 7'b0111111) begin failures++; $display("[TB] FAIL reset seg: got %b, required 0111111", seg); end
    endtask

    task automatic test_single_increment();
        int c;
        do_reset();
        pulse_inc(DIGITS'(1), c);
        repeat (14) tick();
        refresh_check("single");
        checks++;
        if (count_bcd !== 24'h000001) begin
            failures++;
            $display("[TB] FAIL single literal: got %h, required 000001", count_bcd);
        end
    endtask

    task automatic test_carry_timing();
        int c;
        int busy_cycles;
        longint stage [6];
        longint exp_val;
        do_reset();
        repeat (9) pulse_inc(6'b001111, c);
        stage = '{64'd9999, 64'd9990, 64'd9900, 64'd9000, 64'd0, 64'd10000};
        busy_cycles = 0;
        trigger = 6'b000001;
        inc_clk = 1'b1;
        ref_clk = 1'b1;
        for (int m = 0; m <= 6; m++) begin
            tick();
            inc_clk = 1'b0;
            if (busy) busy_cycles++;
            exp_val = (m == 0) ? stage[0] : stage[(m - 1 > 5) ? 5 : m - 1];
            checks++;
            if (count_bcd !== to_bcd(exp_val)) begin
                failures++;
                $display("[TB] FAIL ripple step %0d: count_bcd=%h, required %h", m, count_bcd, to_bcd(exp_val));
            end
            checks++;
            if (busy !== (m < 5)) begin
                failures++;
                $display("[TB] FAIL ripple busy step %0d: got %b, required %b", m, busy, (m < 5));
            end
        end
        ref_clk = 1'b0;
        model_inc(6'b000001);
        checks++;
        if (busy_cycles != 5) begin
            failures++;
            $display("[TB] FAIL ripple busy length: got %0d, required 5", busy_cycles);
        end
        refresh_check("carry");
    endtask

    task automatic test_multi_digit();
        int c;
        do_reset();
        pulse_inc(6'b100100, c);
        refresh_check("multi");
        checks++;
        if (count_bcd !== 24'h100100) begin
            failures++;
            $display("[TB] FAIL multi literal: got %h, required 100100", count_bcd);
        end
    endtask

    task automatic test_random();
        int c;
        logic [DIGITS-1:0] trig;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            trig = DIGITS'($urandom);
            repeat ($urandom_range(1, 4)) pulse_inc(trig, c);
            refresh_check("random");
        end
    endtask

    task automatic test_overflow();
        int c;
        do_reset();
        repeat (9) pulse_inc('1, c);
        refresh_check("all_nines");
        pulse_inc(DIGITS'(1), c);
        checks++;
        if (c != 6) begin
            failures++;
            $display("[TB] FAIL overflow ripple length: got %0d, required 6", c);
        end
        refresh_check("overflow");
        pulse_inc(6'b000010, c);
        refresh_check("overflow_sticky");
    endtask

    task automatic test_coincident_refresh();
        int c;
        longint old_val;
        logic [DIGITS-1:0] trig;
        old_val = model_val;
        trig = DIGITS'($urandom) | DIGITS'(1);
        trigger = trig;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        ref_clk = 1'b1;
        tick();
        ref_clk = 1'b0;
        checks++;
        if (count_bcd !== to_bcd(old_val)) begin
            failures++;
            $display("[TB] FAIL coincident snapshot: got %h, required %h", count_bcd, to_bcd(old_val));
        end
        model_inc(trig);
        wait_idle(c);
        refresh_check("after_coincident");
    endtask

    task automatic test_reset_mid_ripple();
        trigger = '1;
        inc_clk = 1'b1;
        tick();
        inc_clk = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (count_bcd !== '0) begin failures++; $display("[TB] FAIL async count_bcd: got %h, required 0", count_bcd); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL async busy: got %b, required 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL async overflow: got %b, required 0", overflow); end
        checks++;
        if (dig_sel !== DIGITS'(1)) begin failures++; $display("[TB] FAIL async dig_sel: got %b, required 000001", dig_sel); end
        checks++;
        if (seg !== 7'b0111111) begin failures++; $display("[TB] FAIL async seg: got %b, required 0111111", seg); end
        #2 rst_n = 1'b1;
        model_val = 0;
        model_ovf = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post-reset busy: got %b, required 0", busy); end
        refresh_check("post_reset");
    endtask

    task automatic test_scan();
        int idx;
        int guard;
        do_reset();
        load_value(64'd654321);
        refresh_check("scan_load");
        guard = 0;
        while ((edges % SCAN_DIV) != SCAN_DIV / 2 && guard < SCAN_DIV) begin
            tick();
            guard++;
        end
        repeat (SCAN_DIV) tick();
        for (int s = 0; s < 2 * DIGITS; s++) begin
            idx = (edges / SCAN_DIV) % DIGITS;
            checks++;
            if (dig_sel !== DIGITS'(1) << idx) begin
                failures++;
                $display("[TB] FAIL scan dig_sel slot %0d: got %b, required one-hot %0d", s, dig_sel, idx);
            end
            checks++;
            if (seg !== seg_table[digit_of(model_val, idx)]) begin
                failures++;
                $display("[TB] FAIL scan seg slot %0d: got %b, required %b", s, seg, seg_table[digit_of(model_val, idx)]);
            end
            repeat (SCAN_DIV) tick();
        end
    endtask

    initial begin
        seg_table = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        rst_n   = 1'b0;
        inc_clk = 1'b0;
        ref_clk = 1'b0;
        trigger = '0;
        model_val = 0;
        model_ovf = 1'b0;
        tick();
        test_reset();
        test_single_increment();
        test_carry_timing();
        test_multi_digit();
        test_random();
        test_overflow();
        test_coincident_refresh();
        test_reset_mid_ripple();
        test_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
